timer_irq_controller: RTL
=========================

TIMER_IRQ_CONTROLLER -- requirements
Module: timer_irq_controller

Interface
REQ-001 SHALL have parameter VECTOR_BASE, default 8'h00, word offset added to every vector address.
REQ-002 SHALL have port sysClock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port system_reset  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port TIFR_in  input  8  current TIFR flags (7 OCF2, 6 TOV2, 5 ICF1, 4 OCF1A, 3 OCF1B, 2 TOV1, 1 OCF0, 0 TOV0).
REQ-005 SHALL have port TIMSK_in  input  8  interrupt enables, same bit map as TIFR_in.
REQ-006 SHALL have port global_int_enable  input  1  SREG I bit.
REQ-007 SHALL have port cpu_ack  input  1  CPU accepts the request (one-cycle pulse).
REQ-008 SHALL have port reti_done  input  1  CPU finished the handler (one-cycle pulse).
REQ-009 SHALL have port irq_req  output  1  interrupt request to the CPU.
REQ-010 SHALL have port irq_vector  output  8  vector word address of the presented or serviced source.
REQ-011 SHALL have port TIFR_clear_enable  output  1  one-cycle strobe clearing flags in TIFR.
REQ-012 SHALL have port TIFR_clear_mask  output  8  one-hot flag to clear, valid with TIFR_clear_enable.
REQ-013 SHALL have port busy  output  1  high while a handler is in service.

Function
REQ-014 SHALL form pending = TIFR_in & TIMSK_in & {8{global_int_enable}} combinationally.
REQ-015 SHALL use fixed priority bit7 highest to bit0 lowest; vectors VECTOR_BASE + 0x08,0x0A,0x0C,0x0E,0x10,0x12,0x14,0x16 for bits 7..0.
REQ-016 SHALL implement FSM states IDLE, REQ, SERVICE.
REQ-017 IDLE: pending != 0 at edge t -> REQ; irq_req=1 and irq_vector valid from t+1.
REQ-018 REQ: irq_vector SHALL track the highest-priority pending bit every cycle until ack.
REQ-019 REQ: pending == 0 (flag cleared in software or global_int_enable low) -> IDLE, irq_req=0 next cycle, no clear strobe; this takes precedence over a simultaneous cpu_ack.
REQ-020 REQ: cpu_ack with pending != 0 -> latch winning bit and vector; next cycle SERVICE, irq_req=0, busy=1, irq_vector held.
REQ-021 SERVICE: reti_done -> IDLE next cycle, busy=0; pending re-evaluated from IDLE, so re-entry latency is 2 cycles after reti_done.
REQ-022 cpu_ack outside REQ and reti_done outside SERVICE SHALL be ignored.
REQ-023 Flags arriving in SERVICE SHALL remain pending; no nesting, no request while busy=1.
REQ-024 irq_vector SHALL read 8'h00 in IDLE.

Reset
REQ-025 On system_reset: state IDLE, irq_req=0, irq_vector=0, TIFR_clear_enable=0, TIFR_clear_mask=0, busy=0, latched bit cleared; asserting reset mid-REQ or mid-SERVICE SHALL abort without a clear strobe.

Configuration
REQ-026 With TIMER_IRQ_AUTOCLEAR_EN defined: on the REQ->SERVICE transition, TIFR_clear_enable=1 for exactly one cycle with TIFR_clear_mask = one-hot latched bit.
REQ-027 Without TIMER_IRQ_AUTOCLEAR_EN: TIFR_clear_enable and TIFR_clear_mask SHALL be constant 0; software clears flags; all other behaviour unchanged.

Structure
REQ-028 Shared package timer_irq_pkg SHALL hold TIFR bit-index constants, the eight vector offsets and the FSM state enum.
REQ-029 Priority selection SHALL be a separate combinational sub-module irq_priority_encoder (8-bit pending in -> valid, one-hot, vector out).

Verification
REQ-030 TIMSK=0x01, GIE=1, TIFR 0x00->0x01 at t -> irq_req=1, irq_vector=0x16 at t+1; ack -> clear strobe mask 0x01 (AUTOCLEAR_EN), busy=1.
REQ-031 TIMSK=0xFF, TIFR=0x83 -> irq_vector=0x08; ack, reti_done -> next request vector 0x14, then 0x16.
REQ-032 In REQ with vector 0x16, TIFR bit1 set -> irq_vector 0x14 next cycle; ack latches 0x14, mask 0x02.
REQ-033 In REQ, GIE dropped in the same cycle as cpu_ack -> IDLE, irq_req=0, no clear strobe, busy=0.
REQ-034 Reset asserted during SERVICE with vector 0x12 -> all outputs 0 immediately, state IDLE.
REQ-035 Build without TIMER_IRQ_AUTOCLEAR_EN, repeat REQ-030 -> TIFR_clear_enable stays 0; request re-asserts 2 cycles after reti_done while TIFR=0x01.

Source files
------------

// File: rtl/timer_irq_pkg.sv
// Timer interrupt controller shared definitions: TIFR/TIMSK bit map,
// vector word offsets and controller FSM states.
package timer_irq_pkg;

    localparam int unsigned TOV0_BIT  = 0;
    localparam int unsigned OCF0_BIT  = 1;
    localparam int unsigned TOV1_BIT  = 2;
    localparam int unsigned OCF1B_BIT = 3;
    localparam int unsigned OCF1A_BIT = 4;
    localparam int unsigned ICF1_BIT  = 5;
    localparam int unsigned TOV2_BIT  = 6;
    localparam int unsigned OCF2_BIT  = 7;

    localparam logic [7:0] VEC_OCF2  = 8'h08;
    localparam logic [7:0] VEC_TOV2  = 8'h0A;
    localparam logic [7:0] VEC_ICF1  = 8'h0C;
    localparam logic [7:0] VEC_OCF1A = 8'h0E;
    localparam logic [7:0] VEC_OCF1B = 8'h10;
    localparam logic [7:0] VEC_TOV1  = 8'h12;
    localparam logic [7:0] VEC_OCF0  = 8'h14;
    localparam logic [7:0] VEC_TOV0  = 8'h16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority selector for timer interrupt sources (bit7 wins);
// purely combinational, returns one-hot winner and its vector address.
module irq_priority_encoder
    import timer_irq_pkg::*;
#(
    parameter logic [7:0] VECTOR_BASE = 8'h00
) (
    input  logic [7:0] pending_i,
    output logic       valid_o,
    output logic [7:0] onehot_o,
    output logic [7:0] vector_o
);

    always_comb begin
        valid_o  = |pending_i;
        onehot_o = '0;
        vector_o = '0;
        priority case (1'b1)
            pending_i[OCF2_BIT]: begin
                onehot_o[OCF2_BIT] = 1'b1;
                vector_o = VECTOR_BASE + VEC_OCF2;
            end
            pending_i[TOV2_BIT]: begin
                onehot_o[TOV2_BIT] = 1'b1;
                vector_o = VECTOR_BASE + VEC_TOV2;
            end
            pending_i[ICF1_BIT]: begin
                onehot_o[ICF1_BIT] = 1'b1;
                vector_o = VECTOR_BASE + VEC_ICF1;
            end
            pending_i[OCF1A_BIT]: begin
                onehot_o[OCF1A_BIT] = 1'b1;
                vector_o = VECTOR_BASE + VEC_OCF1A;
            end
            pending_i[OCF1B_BIT]: begin
                onehot_o[OCF1B_BIT] = 1'b1;
                vector_o = VECTOR_BASE + VEC_OCF1B;
            end
            pending_i[TOV1_BIT]: begin
                onehot_o[TOV1_BIT] = 1'b1;
                vector_o = VECTOR_BASE + VEC_TOV1;
            end
            pending_i[OCF0_BIT]: begin
                onehot_o[OCF0_BIT] = 1'b1;
                vector_o = VECTOR_BASE + VEC_OCF0;
            end
            pending_i[TOV0_BIT]: begin
                onehot_o[TOV0_BIT] = 1'b1;
                vector_o = VECTOR_BASE + VEC_TOV0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/timer_irq_controller.sv
// Timer interrupt request/service sequencer (IDLE -> REQ -> SERVICE).
// Define TIMER_IRQ_AUTOCLEAR_EN to emit a TIFR clear strobe on acknowledge.
module timer_irq_controller
    import timer_irq_pkg::*;
#(
    parameter logic [7:0] VECTOR_BASE = 8'h00
) (
    input  logic       sysClock,
    input  logic       system_reset,
    input  logic [7:0] TIFR_in,
    input  logic [7:0] TIMSK_in,
    input  logic       global_int_enable,
    input  logic       cpu_ack,
    input  logic       reti_done,
    output logic       irq_req,
    output logic [7:0] irq_vector,
    output logic       TIFR_clear_enable,
    output logic [7:0] TIFR_clear_mask,
    output logic       busy
);

    logic [7:0] pending;
    logic       enc_valid;
    logic [7:0] enc_onehot;
    logic [7:0] enc_vector;

    irq_state_t state_q, state_d;
    logic [7:0] vec_q, vec_d;
    logic [7:0] bit_q, bit_d;
    logic       take;

    assign pending = TIFR_in & TIMSK_in & {8{global_int_enable}};

    irq_priority_encoder #(
        .VECTOR_BASE(VECTOR_BASE)
    ) u_prio (
        .pending_i(pending),
        .valid_o  (enc_valid),
        .onehot_o (enc_onehot),
        .vector_o (enc_vector)
    );

    // Losing pending in REQ beats a simultaneous ack: nothing is serviced.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        bit_d   = bit_q;
        take    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                vec_d = '0;
                if (enc_valid) begin
                    state_d = ST_REQ;
                    vec_d   = enc_vector;
                end
            end
            ST_REQ: begin
                if (!enc_valid) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    bit_d   = '0;
                end else if (cpu_ack) begin
                    state_d = ST_SERVICE;
                    vec_d   = enc_vector;
                    bit_d   = enc_onehot;
                    take    = 1'b1;
                end else begin
                    vec_d   = enc_vector;
                end
            end
            ST_SERVICE: begin
                if (reti_done) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    bit_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vec_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sysClock or posedge system_reset) begin
        if (system_reset) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            bit_q   <= bit_d;
        end
    end

    assign irq_req    = (state_q == ST_REQ);
    assign busy       = (state_q == ST_SERVICE);
    assign irq_vector = vec_q;

`ifdef TIMER_IRQ_AUTOCLEAR_EN
    logic       clr_en_q;
    logic [7:0] clr_mask_q;

    always_ff @(posedge sysClock or posedge system_reset) begin
        if (system_reset) begin
            clr_en_q   <= 1'b0;
            clr_mask_q <= '0;
        end else begin
            clr_en_q   <= take;
            clr_mask_q <= take ? bit_d : 8'h00;
        end
    end

    assign TIFR_clear_enable = clr_en_q;
    assign TIFR_clear_mask   = clr_mask_q;
`else
    logic unused_take;

    assign unused_take       = take;
    assign TIFR_clear_enable = 1'b0;
    assign TIFR_clear_mask   = 8'h00;
`endif

endmodule
